// File: rtl/spi_tx.sv
// SPI master transmit engine: AXIS words shifted out MSB-first with prescaled sclk and cs_n framing.
// Optional back-to-back framing without cs_n deassertion under `define SPI_TX_CONTINUOUS_EN.
module spi_tx #(
  parameter int AXIS_DATA_WIDTH = 8,
  parameter int PRESCALE_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic                       sclk,
  output logic                       txd,
  output logic                       cs_n,
  output logic                       enable_capture,
  input  logic [1:0]                 spi_mode,
  input  logic [5:0]                 spi_word_width,
  input  logic [PRESCALE_WIDTH-1:0]  prescale,
  output logic                       busy
);

  localparam int DW = AXIS_DATA_WIDTH;
  localparam int PW = PRESCALE_WIDTH;
  localparam logic [PW-1:0] ONE_P = 1;

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

  state_t        state, state_n;
  logic [PW-1:0] cnt, cnt_n, pm1, pm1_n;
  logic [5:0]    bit_cnt, bit_cnt_n, wm1, wm1_n;
  logic          half, half_n;
  logic          cpha, cpha_n;
  logic [DW-1:0] sh, sh_n;
  logic          txd_q, txd_n, sclk_q, sclk_n, cs_n_q, cs_n_n;
  logic          en_q;
  logic          load, hs, edge_now, last_edge;

  logic [5:0]    wm1_in;
  logic [PW-1:0] pm1_in;
  logic [6:0]    sa;
  logic [DW-1:0] sh_in;

  // Normalised config and MSB-aligned data for the word being offered
  always_comb begin
    if (spi_word_width == 6'd0 || {26'd0, spi_word_width} > DW)
      wm1_in = 6'(DW - 1);
    else
      wm1_in = spi_word_width - 6'd1;
    pm1_in = (prescale == '0) ? '0 : prescale - ONE_P;
    sa     = 7'(DW - 1) - {1'b0, wm1_in};
    sh_in  = s_axis_tdata << sa;
  end

  assign edge_now  = (state == LEAD || state == SHIFT) && (cnt == '0);
  assign last_edge = edge_now && half && (bit_cnt == wm1);

`ifdef SPI_TX_CONTINUOUS_EN
  assign s_axis_tready = ((state == IDLE) && en_q) || last_edge;
`else
  assign s_axis_tready = (state == IDLE) && en_q;
`endif

  assign hs             = s_axis_tvalid && s_axis_tready;
  assign sclk           = sclk_q;
  assign txd            = txd_q;
  assign cs_n           = cs_n_q;
  assign enable_capture = ~cs_n_q;
  assign busy           = (state != IDLE);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pm1_n     = pm1;
    bit_cnt_n = bit_cnt;
    wm1_n     = wm1;
    half_n    = half;
    cpha_n    = cpha;
    sh_n      = sh;
    txd_n     = txd_q;
    sclk_n    = sclk_q;
    cs_n_n    = cs_n_q;
    load      = 1'b0;

    case (state)
      IDLE: begin
        sclk_n = spi_mode[1];
        txd_n  = 1'b1;
        cs_n_n = 1'b1;
        if (hs) begin
          load    = 1'b1;
          cs_n_n  = 1'b0;
          state_n = LEAD;
        end
      end
      LEAD, SHIFT: begin
        if (cnt != '0) begin
          cnt_n = cnt - ONE_P;
        end else begin
          cnt_n   = pm1;
          sclk_n  = ~sclk_q;
          state_n = SHIFT;
          if (!half) begin
            half_n = 1'b1;
            if (cpha) begin
              txd_n = sh[DW-1];
              sh_n  = {sh[DW-2:0], 1'b1};
            end
          end else begin
            half_n = 1'b0;
            if (!cpha) begin
              txd_n = sh[DW-1];
              sh_n  = {sh[DW-2:0], 1'b1};
            end
            if (bit_cnt == wm1) begin
              state_n = TRAIL;
`ifdef SPI_TX_CONTINUOUS_EN
              // Chain the next word straight onto the final edge; cs_n stays low
              if (hs) begin
                load    = 1'b1;
                state_n = LEAD;
              end
`endif
            end else begin
              bit_cnt_n = bit_cnt + 6'd1;
            end
          end
        end
      end
      TRAIL: begin
        if (cnt != '0) begin
          cnt_n = cnt - ONE_P;
        end else begin
          cnt_n   = pm1;
          cs_n_n  = 1'b1;
          txd_n   = 1'b1;
          state_n = GAP;
        end
      end
      GAP: begin
        if (cnt != '0)
          cnt_n = cnt - ONE_P;
        else
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (load) begin
      cpha_n    = spi_mode[0];
      wm1_n     = wm1_in;
      pm1_n     = pm1_in;
      cnt_n     = pm1_in;
      bit_cnt_n = 6'd0;
      half_n    = 1'b0;
      // CPHA=0 presents the MSB immediately; CPHA=1 waits for the leading edge
      if (spi_mode[0]) begin
        txd_n = 1'b1;
        sh_n  = sh_in;
      end else begin
        txd_n = sh_in[DW-1];
        sh_n  = {sh_in[DW-2:0], 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pm1     <= '0;
      bit_cnt <= 6'd0;
      wm1     <= 6'd0;
      half    <= 1'b0;
      cpha    <= 1'b0;
      sh      <= '0;
      txd_q   <= 1'b1;
      sclk_q  <= spi_mode[1];
      cs_n_q  <= 1'b1;
      en_q    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pm1     <= pm1_n;
      bit_cnt <= bit_cnt_n;
      wm1     <= wm1_n;
      half    <= half_n;
      cpha    <= cpha_n;
      sh      <= sh_n;
      txd_q   <= txd_n;
      sclk_q  <= sclk_n;
      cs_n_q  <= cs_n_n;
      en_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_tx.sv
// Bench for spi_tx (16-bit AXIS): vector table of words, per-bit scoreboard, edge/framing timing model.
module tb_spi_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        sclk, txd, cs_n, enable_capture, busy;
  logic [1:0]  spi_mode;
  logic [5:0]  spi_word_width;
  logic [15:0] prescale;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit exp_q[$];

  spi_tx #(.AXIS_DATA_WIDTH(16), .PRESCALE_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .sclk(sclk), .txd(txd), .cs_n(cs_n), .enable_capture(enable_capture),
    .spi_mode(spi_mode), .spi_word_width(spi_word_width), .prescale(prescale), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  mode;
    logic [5:0]  ww;
    logic [15:0] pre;
    logic [15:0] data;
    int          exp_w;
    int          exp_p;
    logic [15:0] exp_bits;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_bits(input logic [15:0] bits, input int w);
    for (int i = w - 1; i >= 0; i--) exp_q.push_back(bits[i]);
  endtask

  // Handshake one word at a negedge where tready is high; returns at posedge+1 of cycle 0
  task automatic drive_word(input vec_t v, input bit hold);
    int n = 0;
    @(negedge clk);
    while (!s_axis_tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("tready_before_word", s_axis_tready, 1);
    spi_mode       = v.mode;
    spi_word_width = v.ww;
    prescale       = v.pre;
    s_axis_tdata   = v.data;
    s_axis_tvalid  = 1'b1;
    push_bits(v.exp_bits, v.exp_w);
    @(posedge clk);
    #1;
    if (!hold) s_axis_tvalid = 1'b0;
  endtask

  // Follows one word from cycle 1 until tready returns, checking against the timing model
  task automatic watch_word(input vec_t v, output int low_abs, output int rise_abs);
    int   w = v.exp_w;
    int   p = v.exp_p;
    logic cpol = v.mode[1];
    logic cpha = v.mode[0];
    logic prev = cpol;
    int   edges = 0, terr = 0, cs_rise = -1, rdy_c = -1;
    bit   exp_b;
    low_abs  = -1;
    rise_abs = -1;
    for (int c = 1; c <= 2000 && rdy_c < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("cs_n_low_c1", cs_n, 0);
        check("capture_c1", enable_capture, 1);
        check("busy_c1", busy, 1);
        check("sclk_idle_c1", sclk, cpol);
        check("txd_c1", txd, cpha ? 1'b1 : v.exp_bits[w-1]);
        low_abs = cyc;
      end
      if (sclk !== prev) begin
        edges++;
        if (c != 1 + edges * p) terr++;
        if ((edges % 2 == 1) != cpha) begin
          if (exp_q.size() == 0) begin
            check("sb_underflow", 1, 0);
          end else begin
            exp_b = exp_q.pop_front();
            check("txd_bit", txd, exp_b);
          end
        end
        prev = sclk;
      end
      if (cs_n && cs_rise < 0) begin
        cs_rise  = c;
        rise_abs = cyc;
      end
      if (s_axis_tready) rdy_c = c;
    end
    check("edge_count", edges, 2 * w);
    check("edge_timing_errs", terr, 0);
    check("cs_n_rise_cycle", cs_rise, 1 + (2 * w + 1) * p);
    check("tready_cycle", rdy_c, 1 + (2 * w + 2) * p);
    check("sclk_end", sclk, cpol);
  endtask

  task automatic run_vec(input int i);
    int lo, ri;
    drive_word(vecs[i], 1'b0);
    watch_word(vecs[i], lo, ri);
    check("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t va, vb;
    int   lo_a, ri_a, lo_b, ri_b, e, n;
    logic prev;

    //           mode   ww     pre    data      W   P  bits
    vecs[0] = '{2'd0, 6'd8,  16'd2, 16'h00A5, 8,  2, 16'h00A5};
    vecs[1] = '{2'd3, 6'd8,  16'd1, 16'h003C, 8,  1, 16'h003C};
    vecs[2] = '{2'd0, 6'd12, 16'd3, 16'hFABC, 12, 3, 16'h0ABC};
    vecs[3] = '{2'd0, 6'd0,  16'd1, 16'h1234, 16, 1, 16'h1234};
    vecs[4] = '{2'd0, 6'd8,  16'd0, 16'h0081, 8,  1, 16'h0081};
    vecs[5] = '{2'd1, 6'd1,  16'd2, 16'h0001, 1,  2, 16'h0001};
    vecs[6] = '{2'd2, 6'd20, 16'd1, 16'hC3A5, 16, 1, 16'hC3A5};
    vecs[7] = '{2'd1, 6'd5,  16'd4, 16'hFFF5, 5,  4, 16'h0015};

    rst = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    spi_mode = 2'd0;
    spi_word_width = 6'd8;
    prescale = 16'd2;
    repeat (3) @(negedge clk);
    check("rst_tready", s_axis_tready, 0);
    check("rst_sclk", sclk, 0);
    check("rst_txd", txd, 1);
    check("rst_cs_n", cs_n, 1);
    check("rst_capture", enable_capture, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    @(negedge clk);
    check("tready_after_rst", s_axis_tready, 1);

    for (int i = 0; i < 8; i++) run_vec(i);

    // Reset at edge 5 of a CPOL=1 word
    va = '{2'd2, 6'd8, 16'd2, 16'h00A5, 8, 2, 16'h00A5};
    drive_word(va, 1'b0);
    e = 0;
    n = 0;
    prev = 1'b1;
    while (e < 5 && n < 200) begin
      @(negedge clk);
      if (sclk !== prev) e++;
      prev = sclk;
      n++;
    end
    check("reached_edge5", e, 5);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_cs_n", cs_n, 1);
    check("midrst_sclk", sclk, 1);
    check("midrst_txd", txd, 1);
    check("midrst_busy", busy, 0);
    check("midrst_tready", s_axis_tready, 0);
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_tready", s_axis_tready, 1);
    run_vec(0);

    // Two words with tvalid held throughout
    va = vecs[0];
    vb = '{2'd0, 6'd8, 16'd2, 16'h005A, 8, 2, 16'h005A};
    drive_word(va, 1'b1);
    s_axis_tdata = vb.data;
    push_bits(vb.exp_bits, vb.exp_w);
    watch_word(va, lo_a, ri_a);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    watch_word(vb, lo_b, ri_b);
    check("b2b_gap_ge_p", (lo_b - ri_a) >= vb.exp_p, 1);
    check("b2b_sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
